// File: rtl/cdb_rr_arb.sv
// Round-robin CDB arbiter: per-FU result FIFOs feeding one broadcast bus.
// Optional flush support is compiled in with CDB_ARB_FLUSH_EN.
module cdb_rr_arb #(
   parameter int NUM_FU    = 3,
   parameter int TAG_W     = 7,
   parameter int PRD_W     = 7,
   parameter int DATA_W    = 32,
   parameter int BUF_DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_FU-1:0]           fu_valid_i,
   output logic [NUM_FU-1:0]           fu_ready_o,
   input  logic [NUM_FU*TAG_W-1:0]     fu_rob_tag_i,
   input  logic [NUM_FU*PRD_W-1:0]     fu_prd_i,
   input  logic [NUM_FU*DATA_W-1:0]    fu_data_i,
   input  logic [NUM_FU-1:0]           fu_rd_used_i,
`ifdef CDB_ARB_FLUSH_EN
   input  logic                        flush_i,
`endif
   output logic                        cdb_valid_o,
   output logic [TAG_W-1:0]            cdb_rob_tag_o,
   output logic [PRD_W-1:0]            cdb_prd_o,
   output logic [DATA_W-1:0]           cdb_data_o,
   output logic [$clog2(NUM_FU)-1:0]   cdb_src_o
);

   localparam int SRC_W = $clog2(NUM_FU);
   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int ENT_W = TAG_W + PRD_W + DATA_W;

   logic [ENT_W-1:0]  mem_r    [NUM_FU][BUF_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r [NUM_FU];
   logic [PTR_W-1:0]  rd_ptr_r [NUM_FU];
   logic [CNT_W-1:0]  count_r  [NUM_FU];
   logic [SRC_W-1:0]  rr_ptr_r;

   logic [NUM_FU-1:0] ready_s;
   logic [NUM_FU-1:0] nonempty_s;
   logic [NUM_FU-1:0] push_s;
   logic [NUM_FU-1:0] pop_s;
   logic              grant_valid_s;
   logic [SRC_W-1:0]  grant_idx_s;
   logic [ENT_W-1:0]  head_s;
   logic              bcast_s;
   logic              flush_s;

`ifdef CDB_ARB_FLUSH_EN
   assign flush_s = flush_i;
`else
   assign flush_s = 1'b0;
`endif

   assign fu_ready_o = ready_s;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(BUF_DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Per-channel occupancy status and push qualification
   always_comb begin
      ready_s    = {NUM_FU{1'b0}};
      nonempty_s = {NUM_FU{1'b0}};
      push_s     = {NUM_FU{1'b0}};
      for (int i = 0; i < NUM_FU; i++) begin
         ready_s[i]    = (count_r[i] < CNT_W'(BUF_DEPTH));
         nonempty_s[i] = (count_r[i] != {CNT_W{1'b0}});
         push_s[i]     = fu_valid_i[i] & ready_s[i] & ~flush_s;
      end
   end

   // Rotating-priority search: channels at or above rr_ptr first, then the wrap-around
   always_comb begin
      grant_valid_s = 1'b0;
      grant_idx_s   = {SRC_W{1'b0}};
      for (int i = 0; i < NUM_FU; i++) begin
         if (!grant_valid_s && nonempty_s[i] && (SRC_W'(i) >= rr_ptr_r)) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = SRC_W'(i);
         end else begin
         end
      end
      for (int i = 0; i < NUM_FU; i++) begin
         if (!grant_valid_s && nonempty_s[i] && (SRC_W'(i) < rr_ptr_r)) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = SRC_W'(i);
         end else begin
         end
      end
   end

   // Head mux of the granted channel and CDB drive
   always_comb begin
      head_s  = {ENT_W{1'b0}};
      pop_s   = {NUM_FU{1'b0}};
      bcast_s = grant_valid_s & ~flush_s;
      for (int i = 0; i < NUM_FU; i++) begin
         if (grant_idx_s == SRC_W'(i)) begin
            head_s   = mem_r[i][rd_ptr_r[i]];
            pop_s[i] = bcast_s;
         end else begin
         end
      end
      cdb_valid_o = bcast_s;
      if (bcast_s) begin
         {cdb_rob_tag_o, cdb_prd_o, cdb_data_o} = head_s;
         cdb_src_o = grant_idx_s;
      end else begin
         cdb_rob_tag_o = {TAG_W{1'b0}};
         cdb_prd_o     = {PRD_W{1'b0}};
         cdb_data_o    = {DATA_W{1'b0}};
         cdb_src_o     = {SRC_W{1'b0}};
      end
   end

   // FIFO storage, pointers, counts and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_FU; i++) begin
            for (int j = 0; j < BUF_DEPTH; j++) begin
               mem_r[i][j] <= {ENT_W{1'b0}};
            end
            wr_ptr_r[i] <= {PTR_W{1'b0}};
            rd_ptr_r[i] <= {PTR_W{1'b0}};
            count_r[i]  <= {CNT_W{1'b0}};
         end
         rr_ptr_r <= {SRC_W{1'b0}};
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (flush_s) begin
               wr_ptr_r[i] <= {PTR_W{1'b0}};
               rd_ptr_r[i] <= {PTR_W{1'b0}};
               count_r[i]  <= {CNT_W{1'b0}};
            end else begin
               // prd is masked on entry so the CDB never advertises a bogus destination
               if (push_s[i]) begin
                  mem_r[i][wr_ptr_r[i]] <= {fu_rob_tag_i[i*TAG_W +: TAG_W],
                                            fu_rd_used_i[i] ? fu_prd_i[i*PRD_W +: PRD_W] : {PRD_W{1'b0}},
                                            fu_data_i[i*DATA_W +: DATA_W]};
                  wr_ptr_r[i] <= next_ptr(wr_ptr_r[i]);
               end
               if (pop_s[i]) begin
                  rd_ptr_r[i] <= next_ptr(rd_ptr_r[i]);
               end
               case ({push_s[i], pop_s[i]})
                  2'b10:   count_r[i] <= count_r[i] + CNT_W'(1);
                  2'b01:   count_r[i] <= count_r[i] - CNT_W'(1);
                  default: count_r[i] <= count_r[i];
               endcase
            end
         end
         if (flush_s) begin
            rr_ptr_r <= {SRC_W{1'b0}};
         end else if (grant_valid_s) begin
            rr_ptr_r <= (grant_idx_s == SRC_W'(NUM_FU - 1)) ? {SRC_W{1'b0}} : grant_idx_s + SRC_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_cdb_rr_arb.sv
// Self-checking bench for cdb_rr_arb: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_cdb_rr_arb;

   localparam int N  = 3;
   localparam int TW = 7;
   localparam int PW = 7;
   localparam int DW = 32;
   localparam int D  = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    fu_valid, fu_ready, fu_rd_used;
   logic [N*TW-1:0] fu_tag;
   logic [N*PW-1:0] fu_prd;
   logic [N*DW-1:0] fu_data;
   logic            cdb_valid;
   logic [TW-1:0]   cdb_tag;
   logic [PW-1:0]   cdb_prd;
   logic [DW-1:0]   cdb_data;
   logic [1:0]      cdb_src;
`ifdef CDB_ARB_FLUSH_EN
   logic            flush;
`endif

   cdb_rr_arb #(.NUM_FU(N), .TAG_W(TW), .PRD_W(PW), .DATA_W(DW), .BUF_DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n),
      .fu_valid_i(fu_valid), .fu_ready_o(fu_ready),
      .fu_rob_tag_i(fu_tag), .fu_prd_i(fu_prd), .fu_data_i(fu_data), .fu_rd_used_i(fu_rd_used),
`ifdef CDB_ARB_FLUSH_EN
      .flush_i(flush),
`endif
      .cdb_valid_o(cdb_valid), .cdb_rob_tag_o(cdb_tag), .cdb_prd_o(cdb_prd),
      .cdb_data_o(cdb_data), .cdb_src_o(cdb_src)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [2:0] v;
      logic [2:0] u;
      logic [6:0] t0, t1, t2;
      logic [2:0] e_rdy;
      logic       e_val;
      logic [1:0] e_src;
      logic [6:0] e_tag;
      logic [6:0] e_prd;
   } vec_t;
   vec_t tbl[17];

   typedef struct packed {
      logic [6:0]  tag;
      logic [6:0]  prd;
      logic [31:0] data;
   } ent_t;
   ent_t q[N][$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int i, input logic v, input logic [6:0] t, input logic [6:0] p,
                         input logic [31:0] d, input logic u);
      fu_valid[i]         = v;
      fu_tag[i*TW +: TW]  = t;
      fu_prd[i*PW +: PW]  = p;
      fu_data[i*DW +: DW] = d;
      fu_rd_used[i]       = u;
   endtask

   task automatic clear_inputs();
      fu_valid = '0; fu_tag = '0; fu_prd = '0; fu_data = '0; fu_rd_used = '0;
`ifdef CDB_ARB_FLUSH_EN
      flush = 1'b0;
`endif
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic chk_cdb(input string nm, input logic v, input logic [1:0] s, input logic [6:0] t,
                          input logic [6:0] p, input logic [31:0] d);
      chk({nm, "_valid"}, cdb_valid, v);
      chk({nm, "_src"}, cdb_src, s);
      chk({nm, "_tag"}, cdb_tag, t);
      chk({nm, "_prd"}, cdb_prd, p);
      chk({nm, "_data"}, cdb_data, d);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] exp_rdy;
      logic         hv [N];
      logic         hold [N];
      logic [6:0]   rt [N], rp [N];
      logic [31:0]  rdat [N];
      logic         ru [N];
      int           g, rr;
      ent_t         e;

      tbl[0]  = '{3'b000, 3'b000, 7'd0,  7'd0,  7'd0,  3'b111, 1'b0, 2'd0, 7'd0,  7'd0};
      tbl[1]  = '{3'b010, 3'b000, 7'd0,  7'd5,  7'd0,  3'b111, 1'b0, 2'd0, 7'd0,  7'd0};
      tbl[2]  = '{3'b000, 3'b000, 7'd0,  7'd0,  7'd0,  3'b111, 1'b1, 2'd1, 7'd5,  7'd0};
      tbl[3]  = '{3'b111, 3'b111, 7'd10, 7'd11, 7'd12, 3'b111, 1'b0, 2'd0, 7'd0,  7'd0};
      tbl[4]  = '{3'b000, 3'b000, 7'd0,  7'd0,  7'd0,  3'b111, 1'b1, 2'd2, 7'd12, 7'd13};
      tbl[5]  = '{3'b000, 3'b000, 7'd0,  7'd0,  7'd0,  3'b111, 1'b1, 2'd0, 7'd10, 7'd11};
      tbl[6]  = '{3'b000, 3'b000, 7'd0,  7'd0,  7'd0,  3'b111, 1'b1, 2'd1, 7'd11, 7'd12};
      tbl[7]  = '{3'b000, 3'b000, 7'd0,  7'd0,  7'd0,  3'b111, 1'b0, 2'd0, 7'd0,  7'd0};
      tbl[8]  = '{3'b111, 3'b111, 7'd20, 7'd21, 7'd22, 3'b111, 1'b0, 2'd0, 7'd0,  7'd0};
      tbl[9]  = '{3'b111, 3'b111, 7'd23, 7'd24, 7'd25, 3'b111, 1'b1, 2'd2, 7'd22, 7'd23};
      tbl[10] = '{3'b001, 3'b111, 7'd26, 7'd0,  7'd0,  3'b100, 1'b1, 2'd0, 7'd20, 7'd21};
      tbl[11] = '{3'b001, 3'b111, 7'd26, 7'd0,  7'd0,  3'b101, 1'b1, 2'd1, 7'd21, 7'd22};
      tbl[12] = '{3'b000, 3'b000, 7'd0,  7'd0,  7'd0,  3'b110, 1'b1, 2'd2, 7'd25, 7'd26};
      tbl[13] = '{3'b000, 3'b000, 7'd0,  7'd0,  7'd0,  3'b110, 1'b1, 2'd0, 7'd23, 7'd24};
      tbl[14] = '{3'b000, 3'b000, 7'd0,  7'd0,  7'd0,  3'b111, 1'b1, 2'd1, 7'd24, 7'd25};
      tbl[15] = '{3'b000, 3'b000, 7'd0,  7'd0,  7'd0,  3'b111, 1'b1, 2'd0, 7'd26, 7'd27};
      tbl[16] = '{3'b000, 3'b000, 7'd0,  7'd0,  7'd0,  3'b111, 1'b0, 2'd0, 7'd0,  7'd0};

      // Reset held with all valids asserted
      clear_inputs();
      rst_n = 1'b0;
      fu_valid = 3'b111;
      repeat (2) @(posedge clk);
      #1;
      chk_cdb("reset", 1'b0, 2'd0, 7'd0, 7'd0, 32'd0);
      rst_n = 1'b1;
      fu_valid = 3'b000;
      #1;
      chk("reset_ready", fu_ready, 3'b111);
      tick();

      // Vector table: payload derived from tag (prd = tag+1, data = C0DE0000|tag)
      for (int r = 0; r < 17; r++) begin
         set_ch(0, tbl[r].v[0], tbl[r].t0, tbl[r].t0 + 7'd1, 32'hC0DE0000 | 32'(tbl[r].t0), tbl[r].u[0]);
         set_ch(1, tbl[r].v[1], tbl[r].t1, tbl[r].t1 + 7'd1, 32'hC0DE0000 | 32'(tbl[r].t1), tbl[r].u[1]);
         set_ch(2, tbl[r].v[2], tbl[r].t2, tbl[r].t2 + 7'd1, 32'hC0DE0000 | 32'(tbl[r].t2), tbl[r].u[2]);
         chk($sformatf("tbl%0d_ready", r), fu_ready, tbl[r].e_rdy);
         chk_cdb($sformatf("tbl%0d", r), tbl[r].e_val, tbl[r].e_src, tbl[r].e_tag, tbl[r].e_prd,
                 tbl[r].e_val ? (32'hC0DE0000 | 32'(tbl[r].e_tag)) : 32'd0);
         tick();
      end

      // Single LSU result, rd_used=0: no bypass, then broadcast with prd zeroed
      do_reset();
      set_ch(1, 1'b1, 7'd5, 7'd9, 32'h0000DEAD, 1'b0);
      chk("single_nobypass", cdb_valid, 1'b0);
      tick();
      clear_inputs();
      chk_cdb("single", 1'b1, 2'd1, 7'd5, 7'd0, 32'h0000DEAD);
      tick();

      // Fairness: two back-to-back triples both come out in order 0,1,2
      do_reset();
      for (int rep = 0; rep < 2; rep++) begin
         for (int i = 0; i < N; i++) set_ch(i, 1'b1, 7'(40 + rep*3 + i), 7'd3, 32'(100 + i), 1'b1);
         tick();
         clear_inputs();
         for (int i = 0; i < N; i++) begin
            chk_cdb($sformatf("fair%0d_%0d", rep, i), 1'b1, 2'(i), 7'(40 + rep*3 + i), 7'd3, 32'(100 + i));
            tick();
         end
      end

      // Lone channel 0 streaming: push+pop each cycle keeps ready high
      do_reset();
      for (int k = 0; k < 6; k++) begin
         set_ch(0, 1'b1, 7'(60 + k), 7'd1, 32'(k), 1'b1);
         chk($sformatf("bp_ready%0d", k), fu_ready[0], 1'b1);
         if (k == 0) chk("bp_first", cdb_valid, 1'b0);
         else chk_cdb($sformatf("bp%0d", k), 1'b1, 2'd0, 7'(60 + k - 1), 7'd1, 32'(k - 1));
         tick();
      end
      clear_inputs();
      tick();

`ifdef CDB_ARB_FLUSH_EN
      // Flush with full buffers: valid suppressed, buffers empty, rr pointer back to 0
      do_reset();
      for (int i = 0; i < N; i++) set_ch(i, 1'b1, 7'(70 + i), 7'd2, 32'd7, 1'b1);
      tick();
      tick();
      flush = 1'b1;
      chk("flush_valid", cdb_valid, 1'b0);
      tick();
      clear_inputs();
      chk("flush_ready", fu_ready, 3'b111);
      chk("flush_nostale", cdb_valid, 1'b0);
      for (int i = 0; i < N; i++) set_ch(i, 1'b1, 7'(80 + i), 7'd2, 32'd7, 1'b1);
      tick();
      clear_inputs();
      chk("flush_rr", cdb_src, 2'd0);
      chk("flush_rr_tag", cdb_tag, 7'd80);
      repeat (3) tick();
`endif

      // Randomized traffic against the queue model
      do_reset();
      rr = 0;
      for (int i = 0; i < N; i++) begin
         q[i].delete();
         hold[i] = 1'b0;
         hv[i] = 1'b0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!hold[i]) begin
               hv[i]   = ($urandom_range(0, 99) < 40);
               rt[i]   = 7'($urandom);
               rp[i]   = 7'($urandom);
               rdat[i] = $urandom;
               ru[i]   = 1'($urandom);
            end
            set_ch(i, hv[i], rt[i], rp[i], rdat[i], ru[i]);
         end
         exp_rdy = '0;
         g = -1;
         for (int i = 0; i < N; i++) exp_rdy[i] = (q[i].size() < D);
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (rr + k) % N;
            if (g < 0 && q[idx].size() > 0) g = idx;
         end
         chk("rand_ready", fu_ready, exp_rdy);
         if (g >= 0) begin
            e = q[g][0];
            chk_cdb("rand", 1'b1, 2'(g), e.tag, e.prd, e.data);
            void'(q[g].pop_front());
            rr = (g + 1) % N;
         end else begin
            chk_cdb("rand_idle", 1'b0, 2'd0, 7'd0, 7'd0, 32'd0);
         end
         for (int i = 0; i < N; i++) begin
            if (hv[i] && exp_rdy[i]) begin
               q[i].push_back('{tag: rt[i], prd: (ru[i] ? rp[i] : 7'd0), data: rdat[i]});
               hold[i] = 1'b0;
            end else begin
               hold[i] = hv[i];
            end
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
